// File: rtl/tmr0_core.sv
// Timer 0 counting engine: tick selection and synchronization, run/stop FSM,
// counter with rst/ld servicing, overflow/match pulses, output pin and interrupt.
module tmr0_core #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      tmr0_ctrl_i,
  input  logic [WIDTH-1:0] tmr0_val_i,
  input  logic [WIDTH-1:0] tmr0_match_i,
  input  logic [3:0]       ext_tick_i,
  output logic [WIDTH-1:0] tval_o,
  output logic             ovf_set_o,
  output logic             match_set_o,
  output logic             rst_ack_o,
  output logic             ld_ack_o,
  output logic             tmr_out_o,
  output logic             irq_o
);

  typedef enum logic {ST_STOP = 1'b0, ST_RUN = 1'b1} state_t;

  state_t state_q, state_d;

  logic       ctl_on, ctl_rst, ctl_ld, ctl_oinv, ctl_oen, ctl_usesclk;
  logic [1:0] ctl_clksrc;
  logic       unused_ctrl;

  assign ctl_on      = tmr0_ctrl_i[0];
  assign ctl_rst     = tmr0_ctrl_i[1];
  assign ctl_ld      = tmr0_ctrl_i[2];
  assign ctl_oinv    = tmr0_ctrl_i[6];
  assign ctl_oen     = tmr0_ctrl_i[7];
  assign ctl_clksrc  = tmr0_ctrl_i[9:8];
  assign ctl_usesclk = tmr0_ctrl_i[11];
  assign unused_ctrl = ^{tmr0_ctrl_i[31:12], tmr0_ctrl_i[10], tmr0_ctrl_i[5:3]};

  // All four sources are synchronized all the time so a clksrc switch sees settled history.
  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] prev_q;
  logic [3:0] ext_rise;
  logic       tick;

  assign ext_rise = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign tick     = ctl_usesclk | ext_rise[ctl_clksrc];

  logic [WIDTH-1:0] cnt_p0;
  logic [WIDTH-1:0] cnt_nxt;
  logic             ovf_p1, match_p1;
  logic             rst_ack_p1, ld_ack_p1;
  logic             rst_guard_q, ld_guard_q;
  logic             out_q;
  logic             do_rst, do_ld, do_inc;
  logic             ovf_hit, match_hit;

  assign cnt_nxt   = cnt_p0 + 1'b1;
  assign ovf_hit   = &cnt_p0;
  assign match_hit = (cnt_nxt == tmr0_match_i);

  always_comb begin
    state_d = state_q;
    do_rst  = 1'b0;
    do_ld   = 1'b0;
    do_inc  = 1'b0;
    case (state_q)
      ST_STOP: if (ctl_on)  state_d = ST_RUN;
      ST_RUN:  if (!ctl_on) state_d = ST_STOP;
      default: state_d = ST_STOP;
    endcase
    if (ctl_rst) begin
      do_rst = 1'b1;
    end else if (ctl_ld) begin
      do_ld = 1'b1;
    end else if (state_q == ST_RUN && tick) begin
      do_inc = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_STOP;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q      <= '0;
      cnt_p0      <= '0;
      ovf_p1      <= 1'b0;
      match_p1    <= 1'b0;
      rst_ack_p1  <= 1'b0;
      ld_ack_p1   <= 1'b0;
      rst_guard_q <= 1'b0;
      ld_guard_q  <= 1'b0;
      out_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q[0] <= ext_tick_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q    <= sync_q[SYNC_STAGES-1];

      // Guards stay set until the SFR bit is observed low, so each request acks once.
      rst_ack_p1  <= do_rst & ~rst_guard_q;
      ld_ack_p1   <= do_ld & ~ld_guard_q;
      rst_guard_q <= ctl_rst;
      ld_guard_q  <= ctl_ld & (ld_guard_q | do_ld);

      // Counter stage: flag pulses register alongside the increment.
      ovf_p1   <= do_inc & ovf_hit;
      match_p1 <= do_inc & match_hit;
      if (do_rst) begin
        cnt_p0 <= '0;
        out_q  <= 1'b0;
      end else if (do_ld) begin
        cnt_p0 <= tmr0_val_i;
      end else if (do_inc) begin
        cnt_p0 <= cnt_nxt;
        out_q  <= out_q ^ match_hit;
      end
    end
  end

  assign tval_o      = cnt_p0;
  assign ovf_set_o   = ovf_p1;
  assign match_set_o = match_p1;
  assign rst_ack_o   = rst_ack_p1;
  assign ld_ack_o    = ld_ack_p1;
  assign irq_o       = ovf_p1 | match_p1;
  assign tmr_out_o   = ctl_oen & (out_q ^ ctl_oinv);

endmodule

// File: tb/tb_tmr0_core.sv
// Directed bench for tmr0_core: reset, overflow, match/toggle, external tick,
// rst/ld priority with SFR-style clearing, stop/hold and asynchronous reset.
module tb_tmr0_core;

  localparam int WIDTH = 32;
  localparam int SYNC_STAGES = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [31:0]      ctrl;
  logic [WIDTH-1:0] val_i;
  logic [WIDTH-1:0] match_i;
  logic [3:0]       ext_tick;
  logic [WIDTH-1:0] tval;
  logic             ovf_set, match_set, rst_ack, ld_ack, tmr_out, irq;

  logic       c_on, c_rst, c_ld, c_oinv, c_oen, c_usesclk;
  logic [1:0] c_clksrc;

  int pass_cnt = 0;
  int total_cnt = 0;

  assign ctrl = {20'b0, c_usesclk, 1'b0, c_clksrc, c_oen, c_oinv, 3'b0, c_ld, c_rst, c_on};

  always #5 clk = ~clk;

  tmr0_core #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tmr0_ctrl_i  (ctrl),
    .tmr0_val_i   (val_i),
    .tmr0_match_i (match_i),
    .ext_tick_i   (ext_tick),
    .tval_o       (tval),
    .ovf_set_o    (ovf_set),
    .match_set_o  (match_set),
    .rst_ack_o    (rst_ack),
    .ld_ack_o     (ld_ack),
    .tmr_out_o    (tmr_out),
    .irq_o        (irq)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; c_on = 0; c_rst = 0; c_ld = 0; c_oinv = 0; c_oen = 1;
    c_usesclk = 0; c_clksrc = 0; val_i = '0; match_i = 32'h100; ext_tick = '0;
    step(3);
    total_cnt++;
    if (tval !== 32'h0) $display("FAIL reset_tval got %h want 0", tval); else pass_cnt++;
    total_cnt++;
    if ({ovf_set, match_set, rst_ack, ld_ack, irq} !== 5'b0)
      $display("FAIL reset_pulses got %b want 00000", {ovf_set, match_set, rst_ack, ld_ack, irq});
    else pass_cnt++;
    total_cnt++;
    if (tmr_out !== 1'b0) $display("FAIL reset_pin got %b want 0", tmr_out); else pass_cnt++;
    rst_n = 1'b1;
    c_oen = 0;
    step(2);
  endtask

  task automatic test_overflow;
    logic [31:0] exp_t [4];
    exp_t[0] = 32'hFFFF_FFFE; exp_t[1] = 32'hFFFF_FFFF; exp_t[2] = 32'h0; exp_t[3] = 32'h1;
    c_usesclk = 1; c_on = 0; val_i = 32'hFFFF_FFFD; c_ld = 1;
    step(1);
    total_cnt++;
    if (tval !== 32'hFFFF_FFFD || ld_ack !== 1'b1)
      $display("FAIL ovf_load got tval=%h ack=%b want FFFFFFFD/1", tval, ld_ack);
    else pass_cnt++;
    c_ld = 0; c_on = 1;
    step(1);
    total_cnt++;
    if (tval !== 32'hFFFF_FFFD) $display("FAIL ovf_start got %h want FFFFFFFD", tval); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      step(1);
      total_cnt++;
      if (tval !== exp_t[i]) $display("FAIL ovf_cnt%0d got %h want %h", i, tval, exp_t[i]); else pass_cnt++;
      total_cnt++;
      if (ovf_set !== (i == 2) || irq !== (i == 2))
        $display("FAIL ovf_pulse%0d got ovf=%b irq=%b want %b", i, ovf_set, irq, (i == 2));
      else pass_cnt++;
    end
    c_on = 0;
    step(2);
  endtask

  task automatic test_match_toggle;
    logic [31:0] e;
    match_i = 32'd5; c_oen = 1; c_oinv = 0; c_rst = 1;
    step(1);
    total_cnt++;
    if (tval !== 32'h0 || rst_ack !== 1'b1 || tmr_out !== 1'b0)
      $display("FAIL mt_rst got tval=%h ack=%b pin=%b want 0/1/0", tval, rst_ack, tmr_out);
    else pass_cnt++;
    c_rst = 0; c_on = 1;
    step(1);
    for (int k = 1; k <= 7; k++) begin
      step(1);
      total_cnt++;
      if (tval !== k || match_set !== (k == 5) || tmr_out !== (k >= 5))
        $display("FAIL mt_up%0d got tval=%h match=%b pin=%b want %h/%b/%b",
                 k, tval, match_set, tmr_out, k, (k == 5), (k >= 5));
      else pass_cnt++;
    end
    val_i = 32'hFFFF_FFFE; c_ld = 1;
    step(1);
    c_ld = 0;
    for (int j = 1; j <= 7; j++) begin
      step(1);
      e = 32'hFFFF_FFFE + j;
      total_cnt++;
      if (tval !== e || match_set !== (j == 7) || tmr_out !== (j < 7))
        $display("FAIL mt_wrap%0d got tval=%h match=%b pin=%b want %h/%b/%b",
                 j, tval, match_set, tmr_out, e, (j == 7), (j < 7));
      else pass_cnt++;
    end
    total_cnt++;
    if (irq !== 1'b1) $display("FAIL mt_irq got %b want 1", irq); else pass_cnt++;
    c_oinv = 1;
    #1;
    total_cnt++;
    if (tmr_out !== 1'b1) $display("FAIL mt_oinv got %b want 1", tmr_out); else pass_cnt++;
    c_oen = 0;
    #1;
    total_cnt++;
    if (tmr_out !== 1'b0) $display("FAIL mt_oen_off got %b want 0", tmr_out); else pass_cnt++;
    c_oinv = 0; c_on = 0;
    step(2);
  endtask

  task automatic test_ext_tick;
    c_usesclk = 0; c_clksrc = 2; c_rst = 1;
    step(1);
    c_rst = 0; c_on = 1;
    step(2);
    for (int p = 0; p < 10; p++) begin
      ext_tick[2] = 1'b1;
      for (int c = 1; c <= 8; c++) begin
        {ext_tick[3], ext_tick[1], ext_tick[0]} = 3'($urandom_range(0, 7));
        step(1);
        if (c == SYNC_STAGES) begin
          total_cnt++;
          if (tval !== p) $display("FAIL ext_early%0d got %h want %h", p, tval, p); else pass_cnt++;
        end
        if (c == SYNC_STAGES + 1) begin
          total_cnt++;
          if (tval !== p + 1) $display("FAIL ext_land%0d got %h want %h", p, tval, p + 1); else pass_cnt++;
        end
        if (c == 4) ext_tick[2] = 1'b0;
      end
    end
    ext_tick = '0;
    step(4);
    total_cnt++;
    if (tval !== 32'd10) $display("FAIL ext_total got %h want a", tval); else pass_cnt++;
    c_on = 0; c_usesclk = 1;
    step(2);
  endtask

  task automatic test_priority;
    val_i = 32'd5; c_ld = 1;
    step(1);
    c_ld = 0;
    step(1);
    c_on = 1;
    step(3);
    total_cnt++;
    if (tval !== 32'd7) $display("FAIL pri_pre got %h want 7", tval); else pass_cnt++;
    c_rst = 1; c_ld = 1; val_i = 32'hAA;
    step(1);
    total_cnt++;
    if (tval !== 32'h0 || rst_ack !== 1'b1 || ld_ack !== 1'b0)
      $display("FAIL pri_rst got tval=%h rack=%b lack=%b want 0/1/0", tval, rst_ack, ld_ack);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if (tval !== 32'h0 || rst_ack !== 1'b0 || ld_ack !== 1'b0)
      $display("FAIL pri_rst_hold got tval=%h rack=%b lack=%b want 0/0/0", tval, rst_ack, ld_ack);
    else pass_cnt++;
    c_rst = 0;
    step(1);
    total_cnt++;
    if (tval !== 32'hAA || ld_ack !== 1'b1 || rst_ack !== 1'b0)
      $display("FAIL pri_ld got tval=%h lack=%b rack=%b want aa/1/0", tval, ld_ack, rst_ack);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if (tval !== 32'hAA || ld_ack !== 1'b0)
      $display("FAIL pri_ld_hold got tval=%h lack=%b want aa/0", tval, ld_ack);
    else pass_cnt++;
    c_ld = 0;
    step(1);
    total_cnt++;
    if (tval !== 32'hAB || ld_ack !== 1'b0)
      $display("FAIL pri_resume got tval=%h lack=%b want ab/0", tval, ld_ack);
    else pass_cnt++;
  endtask

  task automatic test_stop_hold;
    c_on = 0;
    step(1);
    step(3);
    total_cnt++;
    if (tval !== 32'hAC) $display("FAIL stop_freeze got %h want ac", tval); else pass_cnt++;
    val_i = 32'h1234; c_ld = 1;
    step(1);
    total_cnt++;
    if (tval !== 32'h1234 || ld_ack !== 1'b1)
      $display("FAIL stop_ld got tval=%h ack=%b want 1234/1", tval, ld_ack);
    else pass_cnt++;
    c_ld = 0;
    step(4);
    total_cnt++;
    if (tval !== 32'h1234 || ld_ack !== 1'b0)
      $display("FAIL stop_hold got tval=%h ack=%b want 1234/0", tval, ld_ack);
    else pass_cnt++;
  endtask

  task automatic test_async_reset;
    val_i = 32'h7E; c_ld = 1;
    step(1);
    c_ld = 0; c_on = 1;
    step(3);
    total_cnt++;
    if (tval !== 32'h80) $display("FAIL ar_pre got %h want 80", tval); else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (tval !== 32'h0 || {ovf_set, match_set, rst_ack, ld_ack, irq, tmr_out} !== 6'b0)
      $display("FAIL ar_immediate got tval=%h outs=%b want 0/000000", tval,
               {ovf_set, match_set, rst_ack, ld_ack, irq, tmr_out});
    else pass_cnt++;
    step(2);
    rst_n = 1'b1;
    step(1);
    total_cnt++;
    if (tval !== 32'h0) $display("FAIL ar_first_edge got %h want 0", tval); else pass_cnt++;
    step(1);
    total_cnt++;
    if (tval !== 32'h1) $display("FAIL ar_resume got %h want 1", tval); else pass_cnt++;
    step(1);
    total_cnt++;
    if (tval !== 32'h2) $display("FAIL ar_resume2 got %h want 2", tval); else pass_cnt++;
    c_on = 0;
    step(2);
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_match_toggle();
    test_ext_tick();
    test_priority();
    test_stop_hold();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/tmr0_core.md
# tmr0_core

Timer 0 counting engine: consumes the Timer 0 control, load-value and match-value SFR fields written by the CPU and drives the live count, flag-set pulses, self-clearing-bit acknowledges, output pin and interrupt back to the SFR block. It sits between the SFR register file, which owns storage and software clears of `ovf_f`/`match_f`/`rst`/`ld`, and the pad ring and interrupt controller.

## Interface
- `WIDTH`, 32: counter, load and match width.
- `SYNC_STAGES`, 2: synchronizer depth for the external tick inputs (minimum 2).

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `tmr0_ctrl_i`  in  32  control word, `tmr0_ctrl_t` layout: bit 0 `on`, 1 `rst`, 2 `ld`, 6 `oinv`, 7 `oen`, [9:8] `clksrc`, 11 `usesclk`; flag bits 14/15 are ignored as inputs
- `tmr0_val_i`  in  WIDTH  load value (`tval` SFR)
- `tmr0_match_i`  in  WIDTH  match value (`tmch` SFR)
- `ext_tick_i`  in  4  asynchronous external tick sources, indexed by `clksrc`
- `tval_o`  out  WIDTH  live count, read back through the `tval` SFR
- `ovf_set_o`  out  1  one-cycle pulse; SFR block sets `ovf_f`
- `match_set_o`  out  1  one-cycle pulse; SFR block sets `match_f`
- `rst_ack_o`  out  1  one-cycle pulse; SFR block clears `rst`
- `ld_ack_o`  out  1  one-cycle pulse; SFR block clears `ld`
- `tmr_out_o`  out  1  timer output pin
- `irq_o`  out  1  one-cycle pulse whenever either set pulse fires

## Operation
- Tick source:
  - `usesclk`=1: tick every `clk` cycle.
  - `usesclk`=0: tick on each rising edge of `ext_tick_i[clksrc]`, after a `SYNC_STAGES` synchronizer plus an edge-detect register.
  - All four inputs are synchronized continuously, so changing `clksrc` does not produce a stale edge.
- Two-state FSM:
  - STOP to RUN when `on`=1.
  - RUN to STOP when `on`=0.
  - In STOP, ticks are discarded. `rst` and `ld` are still serviced.
- Per-cycle priority, highest first:
  1. `rst`=1: count <= 0; `rst_ack_o`=1; no flag pulses.
  2. `ld`=1: count <= `tmr0_val_i`; `ld_ack_o`=1; no flag pulses.
  3. RUN and tick: count <= count+1, modulo 2^WIDTH.
- Acknowledges are issued only in the cycle the action is taken.
  - An ack pulse is never repeated while the SFR bit is still visible high in the following cycle.
  - A guard register blocks re-acknowledge until the bit is seen low.
- Overflow: increment from all-ones to 0 gives `ovf_set_o`=1.
- Match: an increment whose result equals `tmr0_match_i` gives `match_set_o`=1.
  - Loads and resets never generate a match.
  - The counter keeps free-running past a match; there is no auto-clear.
- Overflow and match in the same tick (match value 0) raise both pulses in the same cycle.
- Output: toggle register `out_q` flips on every match pulse.
  - `tmr_out_o` = `oen` ? (`out_q` ^ `oinv`) : 0.
  - `rst` also clears `out_q`.
- `irq_o` = `ovf_set_o` | `match_set_o`.

## Timing
- Reset values: `tval_o`=0, `out_q`=0, FSM=STOP, synchronizers=0, all pulse outputs=0, `tmr_out_o`=0.
- `rst_n` asserted mid-count returns everything to the reset values immediately (asynchronous). The first tick is accepted no earlier than the second `clk` edge after deassertion.
- `clk` tick: the counter updates on the edge after `on` is sampled high. Flag pulses are registered outputs, valid in the cycle after the increment edge.
- External tick: rising edge at the pin, then `SYNC_STAGES`+1 `clk` edges, then count updates. External ticks must be low and high for at least 2 `clk` cycles each; faster inputs may lose edges.
- `rst`/`ld` take effect on the first `clk` edge where they are sampled high. The ack is asserted in the following cycle for exactly 1 cycle.
- `tmr_out_o` changes in the same cycle as `match_set_o` is high. `oen`/`oinv` act combinationally on the pin.

## Test plan
- Overflow: `usesclk`=1, `ld` with `tmr0_val_i`=0xFFFF_FFFD, then `on`=1 -> counts FFFFFFFE, FFFFFFFF, 0; exactly one `ovf_set_o` and one `irq_o` pulse, on the wrap.
- Match and toggle: `tmr0_match_i`=5, `oen`=1, `oinv`=0, count from 0 -> `match_set_o` pulses once at count 5; `tmr_out_o` goes 0 to 1 and returns to 0 after the next wrap and match; with `oinv`=1 the pin levels are inverted.
- External tick: `usesclk`=0, `clksrc`=2, 10 pulses on `ext_tick_i[2]` (4 `clk` high / 4 low), noise on the other three inputs -> `tval_o`=10; each increment lands `SYNC_STAGES`+1 cycles after the edge.
- Priority: `rst`, `ld` and a tick all in one cycle with count 7 -> count 0, `rst_ack_o` pulse, no `ld_ack_o`; `ld` held high, then serviced once the SFR clears `rst` -> a single `ld_ack_o` pulse.
- Stop/hold: `on`=0 with ticks present -> count frozen; `ld` of 0x1234 still lands and acks.
- Async reset mid-count at 0x80 with `on`=1 -> all outputs go to reset values without a clock edge; counting resumes from 0 after release.
